event_code_fifo: RTL
====================

EVENT_CODE_FIFO -- requirements
Module: event_code_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  event request lines; bit k high in a cycle = event on line k.
REQ-005 pend  output  8  registered mask of captured, not-yet-queued events.
REQ-006 out_code  output  3  binary index of head event (line number 0..7).
REQ-007 out_valid  output  1  high when FIFO non-empty; out_code then valid.
REQ-008 out_ready  input  1  consumer accepts head when out_valid && out_ready.
REQ-009 count  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-010 merged  output  1  sticky: an event arrived on a line already pending.
REQ-011 clr_merged  input  1  synchronous clear of merged.

Function
REQ-012 Capture: each edge, pend_next = (pend & ~gnt) | req; a req bit set in the same cycle its line is granted SHALL leave that pend bit 1 (set wins).
REQ-013 Grant: when pend != 0 and count < DEPTH, exactly one pend bit SHALL be granted per cycle; no grant when pend == 0 or count == DEPTH.
REQ-014 Arbitration: round-robin; search starts at index (last_grant+1) mod 8 ascending with wrap 7->0; last_grant resets to 7 so first search starts at line 0.
REQ-015 last_grant SHALL update only on a cycle with a grant.
REQ-016 Push: granted line index (3-bit binary) SHALL be written to FIFO tail on the grant edge.
REQ-017 Pop: when out_valid && out_ready, head SHALL advance on that edge.
REQ-018 Full: push gated solely on registered count < DEPTH; a pop in the same cycle SHALL NOT enable a push while count == DEPTH.
REQ-019 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-020 Empty: out_ready with out_valid low SHALL have no effect; out_code value is don't-care while out_valid is low.
REQ-021 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL equal grant order.
REQ-022 Latency: req high before edge E0 -> pend bit high after E0 -> pushed at E1 (if not full and winning) -> out_valid high after E1 when FIFO was empty; no combinational req-to-out path.
REQ-023 merged SHALL set when req[k] && pend[k] && !gnt[k] for any k; clr_merged clears it; set wins over clear in the same cycle.
REQ-024 Events are never dropped: a pending line remains pending until granted, regardless of FIFO state.

Reset
REQ-025 rst_n low SHALL immediately force pend=0, count=0, out_valid=0, merged=0, both FIFO pointers=0, last_grant=7; out_code SHALL read 0.
REQ-026 Reset mid-operation SHALL discard all pending and queued events; FIFO storage need not be cleared.
REQ-027 First edge after rst_n deasserts SHALL sample req normally.

Structure
REQ-028 Shared package event_code_pkg SHALL hold NREQ=8, CODE_W=3 and the reset value of last_grant.
REQ-029 Round-robin selection SHALL be a separate combinational sub-module rr_pick8 (inputs pend, last_grant; outputs gnt one-hot, gnt_code, gnt_any).
REQ-030 FIFO storage and pointers SHALL reside in event_code_fifo.

Verification
REQ-031 Single event: reset, req=8'b0010_0000 one cycle, out_ready=1 -> pend[5] for one cycle, out_valid for one cycle with out_code=5, count returns 0.
REQ-032 Round-robin: req=8'hFF one cycle, out_ready=1 -> codes 0,1,2,...,7 in order on consecutive cycles; next req=8'h81 -> 0 then 7 (search starts after 7 wraps to 0).
REQ-033 Full/backpressure: out_ready=0, req=8'hFF one cycle -> count stops at 4 with codes 0..3 queued, pend=8'hF0 held; raise out_ready -> 0..7 delivered, none lost, no push on the pop cycle while full.
REQ-034 Merge: req[2] two consecutive cycles with FIFO full -> merged=1, only one code 2 delivered; clr_merged pulse -> merged=0; clr_merged with new merge same cycle -> merged stays 1.
REQ-035 Set-wins: req[3] asserted on the cycle line 3 is granted -> pend[3] remains 1, code 3 delivered twice.
REQ-036 Reset mid-stream: rst_n low with count=3 and pend!=0 -> all outputs at reset values immediately; after release, req=8'h40 -> first code out is 6.

Source files
------------

// File: rtl/event_code_pkg.sv
// Shared widths and reset constants for the event code FIFO slice.
// Latency and backpressure: not applicable, because this file holds constants only.
// Used by the arbiter and the FIFO top.
package event_code_pkg;
  localparam int NREQ   = 8;
  localparam int CODE_W = 3;

  typedef logic [CODE_W-1:0] code_t;

  // Start the first search at line 0.
  localparam code_t LAST_GRANT_RST = 3'd7;
endpackage

// File: rtl/rr_pick8.sv
// Round-robin picker over 8 pending lines. The search starts just after last_grant.
// Latency: combinational, 0 cycles.
// Backpressure: none here; the caller gates the grant.
module rr_pick8
  import event_code_pkg::*;
(
  input  logic [NREQ-1:0] pend,
  input  code_t           last_grant,
  output logic [NREQ-1:0] gnt,
  output code_t           gnt_code,
  output logic            gnt_any
);

  code_t idx;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_code = '0;
    idx      = '0;
    // Offsets run 1..NREQ, so last_grant itself is the final candidate.
    for (int i = 1; i <= NREQ; i++) begin
      idx = last_grant + CODE_W'(i);
      if (!gnt_any && pend[idx]) begin
        gnt_any  = 1'b1;
        gnt_code = idx;
      end
    end
    gnt = gnt_any ? (NREQ'(1) << gnt_code) : '0;
  end

endmodule

// File: rtl/event_code_fifo.sv
// Captures event lines into a pending mask and queues them, in round-robin order, as 3-bit codes.
// Latency: req -> pend after 1 edge -> out_valid after 2 edges when the FIFO is empty.
// Backpressure: a full FIFO stalls grants on registered count only; pending lines wait and are never dropped.
module event_code_fifo
  import event_code_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          pend,
  output logic [CODE_W-1:0]        out_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     merged,
  input  logic                     clr_merged
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  code_t           mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  code_t           last_grant;

  logic [NREQ-1:0] pick_gnt;
  code_t           pick_code;
  logic            pick_any;
  logic [NREQ-1:0] gnt;
  logic            full;
  logic            push;
  logic            pop;
  logic            merge_hit;

  rr_pick8 u_pick (
    .pend       (pend),
    .last_grant (last_grant),
    .gnt        (pick_gnt),
    .gnt_code   (pick_code),
    .gnt_any    (pick_any)
  );

  // Full is judged on registered count, so a same-cycle pop never opens room for a push.
  assign full      = (count == CW'(DEPTH));
  assign push      = pick_any && !full;
  assign gnt       = push ? pick_gnt : '0;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_code  = out_valid ? mem[rd_ptr] : '0;
  assign merge_hit = |(req & pend & ~gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      last_grant <= LAST_GRANT_RST;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      merged     <= 1'b0;
    end else begin
      pend   <= (pend & ~gnt) | req;
      merged <= merge_hit | (merged & ~clr_merged);
      if (push) begin
        last_grant <= pick_code;
        wr_ptr     <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage holds no reset; out_code is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pick_code;
    end
  end

endmodule
